// File: rtl/isqrt_iter.sv
// Iterative integer square root: floor(sqrt(value)) and value - root^2 using a
// restoring digit-by-digit recurrence, BITS_PER_CYCLE root bits per clock.
module isqrt_iter #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     value,
    output logic                 ready,
    output logic [WIDTH/2-1:0]   result,
    output logic [WIDTH/2:0]     remainder,
    output logic                 done
);
    localparam int H  = WIDTH / 2;
    localparam int N  = WIDTH / (2 * BITS_PER_CYCLE);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] rad_reg, rad_next;
    logic [H-1:0]     root_reg, root_next;
    logic [H+1:0]     rem_reg, rem_next;
    logic [CW-1:0]    cnt_reg, cnt_next;

    // Sub-step chain: stage gi feeds stage gi+1 within one clock.
    logic [WIDTH-1:0] rad_s  [BITS_PER_CYCLE+1];
    logic [H-1:0]     root_s [BITS_PER_CYCLE+1];
    logic [H+1:0]     rem_s  [BITS_PER_CYCLE+1];

    assign rad_s[0]  = rad_reg;
    assign root_s[0] = root_reg;
    assign rem_s[0]  = rem_reg;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            logic [H+1:0] rem_sh;
            logic [H+1:0] trial;
            logic         ge;
            // The partial remainder stays below 2^H before each step, so the
            // bits shifted out of the top are always zero.
            assign rem_sh = (rem_s[gi] << 2) | (H+2)'(rad_s[gi][WIDTH-1 -: 2]);
            assign trial  = ({2'b00, root_s[gi]} << 2) | (H+2)'(1);
            assign ge     = (rem_sh >= trial);
            assign rem_s[gi+1]  = ge ? (rem_sh - trial) : rem_sh;
            assign root_s[gi+1] = (root_s[gi] << 1) | H'(ge);
            assign rad_s[gi+1]  = rad_s[gi] << 2;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        rad_next   = rad_reg;
        root_next  = root_reg;
        rem_next   = rem_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    rad_next   = value;
                    root_next  = '0;
                    rem_next   = '0;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                rad_next  = rad_s[BITS_PER_CYCLE];
                root_next = root_s[BITS_PER_CYCLE];
                rem_next  = rem_s[BITS_PER_CYCLE];
                cnt_next  = cnt_reg + CW'(1);
                if (cnt_reg == CW'(N - 1))
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            rad_reg   <= '0;
            root_reg  <= '0;
            rem_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            rad_reg   <= rad_next;
            root_reg  <= root_next;
            rem_reg   <= rem_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign ready     = (state_reg != RUN);
    assign done      = (state_reg == DONE);
    assign result    = done ? root_reg : '0;
    assign remainder = done ? rem_reg[H:0] : '0;
endmodule

// File: tb/tb_isqrt_iter.sv
// Bench for isqrt_iter: one instance per BITS_PER_CYCLE setting, checked
// against a binary-search square-root model.
module tb_isqrt_iter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0, start2 = 1'b0;
    logic [63:0] value1 = '0, value2 = '0;
    logic        ready1, ready2, done1, done2;
    logic [31:0] result1, result2;
    logic [32:0] remainder1, remainder2;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    isqrt_iter #(.WIDTH(64), .BITS_PER_CYCLE(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .value(value1),
        .ready(ready1), .result(result1), .remainder(remainder1), .done(done1)
    );

    isqrt_iter #(.WIDTH(64), .BITS_PER_CYCLE(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .value(value2),
        .ready(ready2), .result(result2), .remainder(remainder2), .done(done2)
    );

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_sqrt(input logic [63:0] v);
        logic [65:0] lo, hi, mid;
        lo = 0;
        hi = 66'h1_0000_0000;
        while (hi - lo > 1) begin
            mid = (lo + hi) >> 1;
            if (mid * mid <= {2'b00, v}) lo = mid;
            else hi = mid;
        end
        return lo[31:0];
    endfunction

    // sel 0 -> one bit per cycle instance, 1 -> two bits per cycle instance.
    task automatic run_op(input int sel, input logic [63:0] v, input bit hold,
                          input bit disturb, input bit verbose);
        int          n, k, lat;
        logic        d, r;
        logic [31:0] res, exp_r;
        logic [32:0] rm;
        logic [65:0] sq, sq1;
        n = (sel == 0) ? 32 : 16;
        @(negedge clock);
        if (sel == 0) begin value1 = v; start1 = 1'b1; end
        else begin value2 = v; start2 = 1'b1; end
        @(posedge clock); #1;
        d = (sel == 0) ? done1 : done2;
        r = (sel == 0) ? ready1 : ready2;
        check("accept_done_low", d, 0);
        check("accept_ready_low", r, 0);
        if (!hold) begin start1 = 1'b0; start2 = 1'b0; end
        lat = -1;
        for (k = 1; k <= n + 4; k++) begin
            if (disturb && k == 3) begin
                if (sel == 0) begin value1 = ~v; start1 = 1'b1; end
                else begin value2 = ~v; start2 = 1'b1; end
            end
            if (disturb && k == 4 && !hold) begin start1 = 1'b0; start2 = 1'b0; end
            @(posedge clock); #1;
            d = (sel == 0) ? done1 : done2;
            if (d) begin lat = k; break; end
        end
        check("latency", lat, n);
        res   = (sel == 0) ? result1 : result2;
        rm    = (sel == 0) ? remainder1 : remainder2;
        exp_r = ref_sqrt(v);
        check("result", res, exp_r);
        check("remainder", rm, {2'b00, v} - {34'd0, exp_r} * {34'd0, exp_r});
        sq  = {34'd0, res} * {34'd0, res};
        sq1 = ({34'd0, res} + 66'd1) * ({34'd0, res} + 66'd1);
        check("bounds", (sq <= {2'b00, v}) && ({2'b00, v} < sq1), 1);
        if (verbose)
            $display("op bpc=%0d value=0x%0h result=0x%0h remainder=0x%0h latency=%0d",
                     sel + 1, v, res, rm, lat);
    endtask

    initial begin
        logic [63:0] rv;
        int          k;
        bit          seen;

        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        for (k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            check("rst_ready", ready1, 1);
            check("rst_done", done1, 0);
            check("rst_result", result1, 0);
            check("rst_remainder", remainder1, 0);
        end
        $display("reset idle checks done");

        // Back-to-back with start held high from DONE.
        run_op(0, 64'd0, 1, 0, 1);
        run_op(0, 64'd17, 1, 0, 1);
        run_op(0, 64'd1000000, 1, 0, 1);
        run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1);
        check("max_result", result1, 32'hFFFF_FFFF);
        check("max_remainder", remainder1, 33'h1_FFFF_FFFE);

        // Abort mid-RUN with reset, then a fresh operation.
        @(negedge clock); value1 = 64'd1000000; start1 = 1'b1;
        @(posedge clock); #1; start1 = 1'b0;
        seen = 0;
        for (k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            if (done1) seen = 1;
        end
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        check("abort_ready", ready1, 1);
        check("abort_done", done1, 0);
        check("abort_result", result1, 0);
        @(negedge clock); reset = 1'b0;
        for (k = 0; k < 30; k++) begin
            @(posedge clock); #1;
            if (done1) seen = 1;
        end
        check("abort_no_done", seen, 0);
        $display("reset mid-run checks done");
        run_op(0, 64'd144, 0, 0, 1);
        check("sq144_result", result1, 32'd12);

        // start pulse and value change during RUN are ignored.
        run_op(0, 64'd123456789, 0, 1, 1);

        // Two bits per cycle: corner values then random radicands.
        run_op(1, 64'd0, 1, 0, 1);
        run_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1);
        run_op(1, 64'hFFFF_FFFE_0000_0001, 1, 0, 1);
        run_op(1, 64'd99, 1, 1, 1);
        for (int i = 0; i < 4000; i++) begin
            rv = {$urandom, $urandom};
            if (i % 4 == 1) rv = rv >> $urandom_range(63, 0);
            run_op(1, rv, 1, 0, 1);
        end
        start2 = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
